// File: rtl/i2c_arbiter.sv
// Round-robin arbiter that shares one single-byte I2C master engine between NUM_REQ requesters.
// Handshake: a requester holds req_valid and its fields until the one-cycle req_ready pulse.
module i2c_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ-1:0]   req_rw,
    input  logic [7*NUM_REQ-1:0] req_addr,
    input  logic [8*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [7:0]           rsp_rdata,
    output logic                 rsp_nack,
    output logic                 rsp_timeout,
    output logic                 busy,
    output logic                 m_req,
    output logic                 m_rw,
    output logic [6:0]           m_addr,
    output logic [7:0]           m_wdata,
    input  logic [7:0]           m_rdata,
    input  logic                 m_done,
    input  logic                 m_ack_err
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int WD_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [WD_W-1:0] WD_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DONE_LOW, S_DRAIN
    } state_e;

    state_e               state_q;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]     owner_q;
    logic                 rw_q;
    logic [6:0]           addr_q;
    logic [7:0]           wdata_q;
    logic [WD_W-1:0]      wd_cnt_q;
    logic                 done_q;
    logic                 drain_q;
    logic                 m_req_q;
    logic                 busy_q;
    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic [7:0]           rsp_rdata_q;
    logic                 rsp_nack_q;
    logic                 rsp_timeout_q;

    logic                 any_valid;
    logic [PTR_W-1:0]     grant_idx;
    logic [NUM_REQ-1:0]   owner_oh;
    logic                 done_rise;
    logic                 wd_expired;

    // First requester at or above rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        int j;
        logic [PTR_W-1:0] idx;
        any_valid = 1'b0;
        grant_idx = '0;
        j         = 0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(rr_ptr_q) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            idx = PTR_W'(j);
            if (!any_valid && req_valid[idx]) begin
                any_valid = 1'b1;
                grant_idx = idx;
            end
        end
        rr_ptr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && state_q == S_IDLE && any_valid) req_ready[grant_idx] = 1'b1;
    end

    assign owner_oh   = NUM_REQ'(1) << owner_q;
    assign done_rise  = m_done & ~done_q;
    assign wd_expired = (TIMEOUT_CYC != 0) && (wd_cnt_q == WD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            owner_q       <= '0;
            rw_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wd_cnt_q      <= '0;
            done_q        <= 1'b0;
            drain_q       <= 1'b0;
            m_req_q       <= 1'b0;
            busy_q        <= 1'b0;
            rsp_valid_q   <= '0;
            rsp_rdata_q   <= '0;
            rsp_nack_q    <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            done_q      <= m_done;
            rsp_valid_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (any_valid) begin
                        owner_q  <= grant_idx;
                        rw_q     <= req_rw[grant_idx];
                        addr_q   <= req_addr[7*grant_idx +: 7];
                        wdata_q  <= req_wdata[8*grant_idx +: 8];
                        busy_q   <= 1'b1;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= S_ISSUE;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    m_req_q  <= 1'b1;
                    wd_cnt_q <= '0;
                    drain_q  <= 1'b0;
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    if (wd_cnt_q != WD_MAX) wd_cnt_q <= wd_cnt_q + 1'b1;
                    if (done_rise) begin
                        m_req_q       <= 1'b0;
                        rsp_rdata_q   <= m_rdata;
                        rsp_nack_q    <= m_ack_err;
                        rsp_timeout_q <= 1'b0;
                        rsp_valid_q   <= owner_oh;
                        state_q       <= S_RESP;
                    end else if (wd_expired) begin
                        m_req_q       <= 1'b0;
                        rsp_rdata_q   <= '0;
                        rsp_nack_q    <= 1'b0;
                        rsp_timeout_q <= 1'b1;
                        rsp_valid_q   <= owner_oh;
                        drain_q       <= 1'b1;
                        state_q       <= S_RESP;
                    end
                end
                S_RESP: begin
                    state_q <= drain_q ? S_DRAIN : S_DONE_LOW;
                end
                S_DONE_LOW: begin
                    if (!m_done) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    // Level test: done high here can only have risen after expiry, even if during RESP.
                    if (m_done) state_q <= S_DONE_LOW;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_nack    = rsp_nack_q;
    assign rsp_timeout = rsp_timeout_q;
    assign busy        = busy_q;
    assign m_req       = m_req_q;
    assign m_rw        = rw_q;
    assign m_addr      = addr_q;
    assign m_wdata     = wdata_q;
endmodule

// File: doc/i2c_arbiter.md
Name: i2c_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one single-byte I2C master engine between NUM_REQ on-chip requesters.
- Accepts one byte transaction per grant (write or read, 7-bit address) and drives the engine's level request.
- Detects the engine's completion and returns read data plus error status to the owning requester.
- Includes a watchdog that reports a hung transfer.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYC, 200000, clk cycles allowed from m_req rise to m_done rise; 0 disables watchdog

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester transaction request, held until req_ready
req_ready  out  NUM_REQ  one-hot grant/accept pulse
req_rw  in  NUM_REQ  per-requester direction, 0=write, 1=read
req_addr  in  7*NUM_REQ  per-requester slave address, requester i at [7i+6:7i]
req_wdata  in  8*NUM_REQ  per-requester write byte, requester i at [8i+7:8i]
rsp_valid  out  NUM_REQ  one-hot completion pulse to owner
rsp_rdata  out  8  read byte, valid with rsp_valid
rsp_nack  out  1  slave NACK status, valid with rsp_valid
rsp_timeout  out  1  watchdog expired, valid with rsp_valid
busy  out  1  high from grant until return to IDLE
m_req  out  1  engine request (level)
m_rw  out  1  engine direction
m_addr  out  7  engine address
m_wdata  out  8  engine write byte
m_rdata  in  8  engine read byte
m_done  in  1  engine completion, high for one or more cycles
m_ack_err  in  1  engine NACK flag

Behaviour:
- Reset: state IDLE; all outputs 0; rr_ptr=0; the latched owner, rw, addr, and wdata registers=0; wd_cnt=0; done_q=0.
- done_q: m_done registered each cycle. done_rise = m_done & ~done_q.
- IDLE:
  - If any req_valid, select the first set bit searching upward from rr_ptr, wrapping at NUM_REQ.
  - Same cycle: pulse req_ready[g]=1 and latch owner=g plus req_rw/addr/wdata[g] into m_rw/m_addr/m_wdata.
  - Set busy=1 and rr_ptr=(g+1) mod NUM_REQ; go to ISSUE.
  - No req_valid: remain, busy=0.
- ISSUE (1 cycle): m_req=1, wd_cnt=0 -> WAIT.
- WAIT: m_req held 1, m_rw/m_addr/m_wdata held stable, wd_cnt increments.
  - On done_rise: m_req=0 next cycle; capture rsp_rdata=m_rdata and rsp_nack=m_ack_err (sampled in the done_rise cycle); rsp_timeout=0 -> RESP.
  - Else if TIMEOUT_CYC!=0 and wd_cnt==TIMEOUT_CYC-1: m_req=0; rsp_timeout=1, rsp_nack=0, rsp_rdata=0 -> RESP with drain flag set.
  - done_rise in the same cycle as expiry: done wins, no timeout.
- RESP (1 cycle): rsp_valid[owner]=1 for exactly one cycle; rsp_* are held until the next RESP.
  - drain flag clear -> DONE_LOW.
  - drain flag set -> DRAIN.
- DONE_LOW: wait m_done==0, then -> IDLE. Prevents re-granting while the engine's done is still high. busy=0 on entry to IDLE.
- DRAIN: m_req=0. Wait for done_rise; no response is issued. Then -> DONE_LOW. Engine is never re-requested mid-transfer.
- m_req deasserts within 1 clk of done_rise, so engines whose IDLE samples request on a slow tick must not restart.
- req_valid deasserted before grant: request is dropped silently. Requesters must hold their fields stable while req_valid=1.
- Lowest index wins only relative to rr_ptr; a continuously requesting requester is re-served after at most NUM_REQ-1 others.
- Reset mid-operation: immediate return to reset values, m_req=0, no rsp_valid.
- wd_cnt width: $clog2(TIMEOUT_CYC+1), saturating, never wraps.

Test Plan:
- Write: req0 rw=0 addr=0x50 wdata=0xA5 -> req_ready[0] pulse; m_addr=0x50 and m_wdata=0xA5 while m_req=1; m_done 4-cycle pulse with m_ack_err=0 -> rsp_valid[0] single pulse, rsp_nack=0; m_req low 1 clk after done rise.
- Read: req2 rw=1 addr=0x3C; engine returns m_rdata=0x5A -> rsp_valid[2], rsp_rdata=0x5A; no new grant until m_done low.
- Round-robin: req0..3 valid simultaneously and held -> grant order 0,1,2,3,0. Then with only req1 and req3 valid, rr_ptr=1 -> order 1,3,1.
- NACK: m_ack_err=1 at done rise -> rsp_nack=1 to owner, rsp_timeout=0.
- Timeout: TIMEOUT_CYC=50, no m_done -> m_req drops at cycle 50, rsp_valid with rsp_timeout=1. A later m_done pulse gives no rsp_valid. The next pending request is granted only after m_done falls.
- Reset mid-WAIT: rst_n low -> m_req=0, busy=0, no rsp_valid. After release, a pending req is granted from index 0.
